// File: rtl/strobe_monitor_if.sv
// strobe_monitor_if: groups the sampling inputs and monitor outputs of
// strobe_monitor.
//   master : drives i_enable / i_strobe / i_clear_errors, observes results
//   slave  : the monitor itself
// Signals:
//   i_enable        sampling qualifier
//   i_strobe        strobe under test
//   i_clear_errors  synchronous clear of o_err_count
//   o_locked        high while locked to the expected period
//   o_period        last measured rising-edge spacing (saturating)
//   o_err_count     saturating error counter
//   o_error         one-cycle pulse per error event
interface strobe_monitor_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 i_enable;
  logic                 i_strobe;
  logic                 i_clear_errors;
  logic                 o_locked;
  logic [CNT_WIDTH-1:0] o_period;
  logic [15:0]          o_err_count;
  logic                 o_error;

  modport master (
    output i_enable, i_strobe, i_clear_errors,
    input  o_locked, o_period, o_err_count, o_error
  );

  modport slave (
    input  i_enable, i_strobe, i_clear_errors,
    output o_locked, o_period, o_err_count, o_error
  );
endinterface

// File: rtl/strobe_monitor.sv
// strobe_monitor: receive-side checker for a periodic valid strobe.
// Measures the spacing between rising edges of i_strobe (counted in enabled
// cycles), locks after LOCK_COUNT consecutive intervals equal to EXP_PERIOD,
// and while locked flags wrong-period or missing strobes.
// Ports:
//   clock    system clock, rising edge
//   i_reset  asynchronous active-high reset
//   mon      strobe_monitor_if.slave (enable/strobe/clear in, status out)
module strobe_monitor #(
  parameter int CNT_WIDTH    = 8,
  parameter int EXP_PERIOD   = 5,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 2
) (
  input  logic              clock,
  input  logic              i_reset,
  strobe_monitor_if.slave   mon
);

  localparam int MW = CNT_WIDTH + 1;
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  state_t               state;
  state_t               state_nx;
  logic                 strb_d;
  logic [CNT_WIDTH-1:0] interval;
  logic [GW-1:0]        good;
  logic [BW-1:0]        bad;
  logic [CNT_WIDTH-1:0] period_q;
  logic [15:0]          err_cnt;
  logic                 err_q;

  logic                 rise;
  logic [MW-1:0]        meas;
  logic                 match;
  logic                 missing;
  logic                 bad_ev;
  logic                 good_hit;
  logic                 bad_hit;

  // Event decode. meas is one bit wider than interval so a saturated
  // interval still yields a value that can never equal EXP_PERIOD.
  always_comb begin
    rise     = mon.i_enable & mon.i_strobe & ~strb_d;
    meas     = {1'b0, interval} + MW'(1);
    match    = (meas == MW'(EXP_PERIOD));
    missing  = mon.i_enable & ~rise & (state == LOCKED) &
               (meas == MW'(2 * EXP_PERIOD));
    bad_ev   = (state == LOCKED) & ((rise & ~match) | missing);
    good_hit = (state == TRACK) & rise & match & (good == GW'(LOCK_COUNT - 1));
    bad_hit  = bad_ev & (bad == BW'(UNLOCK_COUNT - 1));
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (rise)     state_nx = TRACK;
      TRACK:   if (good_hit) state_nx = LOCKED;
      LOCKED:  if (bad_hit)  state_nx = TRACK;
      default:               state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      strb_d   <= 1'b0;
      interval <= '0;
      good     <= '0;
      bad      <= '0;
      period_q <= '0;
      err_cnt  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (mon.i_enable) begin
        strb_d <= mon.i_strobe;

        // A missing strobe restarts the interval as if an edge had arrived.
        if (rise || missing) begin
          interval <= '0;
        end else if (interval != '1) begin
          interval <= interval + CNT_WIDTH'(1);
        end

        if (rise && state != IDLE) begin
          period_q <= meas[CNT_WIDTH] ? '1 : meas[CNT_WIDTH-1:0];
        end

        if (state == TRACK && rise) begin
          if (!match || good_hit) good <= '0;
          else                    good <= good + GW'(1);
        end else if (state != TRACK) begin
          good <= '0;
        end

        if (state == LOCKED) begin
          if (rise && match)  bad <= '0;
          else if (bad_hit)   bad <= '0;
          else if (bad_ev)    bad <= bad + BW'(1);
        end else begin
          bad <= '0;
        end
      end

      // bad_ev is already qualified by i_enable, so the pulse drops to 0
      // on disabled cycles.
      err_q <= bad_ev;

      // Clear wins over the old count but not over a coincident error.
      if (mon.i_clear_errors) begin
        err_cnt <= {15'b0, bad_ev};
      end else if (bad_ev && err_cnt != '1) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    mon.o_locked    = (state == LOCKED);
    mon.o_period    = period_q;
    mon.o_err_count = err_cnt;
    mon.o_error     = err_q;
  end

endmodule

// File: tb/tb_strobe_monitor.sv
// Scoreboard bench for strobe_monitor: a reference model derived from the
// edge-spacing rules predicts the outputs after every clock; a separate
// monitor compares them half a cycle later.
module tb_strobe_monitor;

  localparam int CW     = 8;
  localparam int EXP    = 5;
  localparam int LOCK   = 4;
  localparam int UNLOCK = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  strobe_monitor_if #(.CNT_WIDTH(CW)) bus ();

  strobe_monitor #(
    .CNT_WIDTH    (CW),
    .EXP_PERIOD   (EXP),
    .LOCK_COUNT   (LOCK),
    .UNLOCK_COUNT (UNLOCK)
  ) dut (
    .clock   (clk),
    .i_reset (rst),
    .mon     (bus)
  );

  typedef struct {
    bit locked;
    int period;
    int err;
    bit error;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: spacing measured as a count of enabled cycles.
  bit m_prev, m_seen, m_locked, m_error;
  int m_elapsed, m_good, m_bad, m_period, m_err;

  task automatic model_reset();
    m_prev = 0; m_seen = 0; m_locked = 0; m_error = 0;
    m_elapsed = 0; m_good = 0; m_bad = 0; m_period = 0; m_err = 0;
  endtask

  task automatic model_step(bit en, bit stb, bit clr);
    bit is_bad;
    bit rise;
    int spacing;
    is_bad = 0;
    if (en) begin
      rise   = stb && !m_prev;
      m_prev = stb;
      if (m_elapsed < 100000) m_elapsed++;
      if (rise) begin
        spacing   = m_elapsed;
        m_elapsed = 0;
        if (!m_seen) begin
          m_seen = 1;
        end else begin
          m_period = (spacing > 255) ? 255 : spacing;
          if (!m_locked) begin
            if (spacing == EXP) begin
              m_good++;
              if (m_good == LOCK) begin
                m_locked = 1; m_good = 0; m_bad = 0;
              end
            end else begin
              m_good = 0;
            end
          end else if (spacing == EXP) begin
            m_bad = 0;
          end else begin
            is_bad = 1;
          end
        end
      end else if (m_locked && m_elapsed == 2 * EXP) begin
        m_elapsed = 0;
        is_bad    = 1;
      end
      if (is_bad) begin
        m_bad++;
        if (m_bad == UNLOCK) begin
          m_locked = 0; m_good = 0; m_bad = 0;
        end
      end
    end
    if (clr)                         m_err = is_bad ? 1 : 0;
    else if (is_bad && m_err < 65535) m_err++;
    m_error = is_bad;
  endtask

  function automatic void chk(string name, int act, int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endfunction

  // Monitor: compares the DUT against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("locked",    int'(bus.o_locked),    int'(e.locked));
        chk("period",    int'(bus.o_period),    e.period);
        chk("err_count", int'(bus.o_err_count), e.err);
        chk("error",     int'(bus.o_error),     int'(e.error));
      end
    end
  end

  task automatic step(bit en, bit stb, bit clr);
    exp_t e;
    bus.i_enable       = en;
    bus.i_strobe       = stb;
    bus.i_clear_errors = clr;
    model_step(en, stb, clr);
    e.locked = m_locked;
    e.period = m_period;
    e.err    = m_err;
    e.error  = m_error;
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  // One strobe period of n enabled cycles; edge at its first cycle, strobe
  // held high for 'hold' cycles. Disabled cycles are interleaved at dis_pct.
  task automatic period(int n, int hold, int dis_pct, int clr_pct);
    for (int k = 0; k < n; k++) begin
      if (dis_pct > 0 && int'($urandom_range(99)) < dis_pct)
        step(1'b0, 1'($urandom_range(1)), 1'b0);
      step(1'b1, k < hold, (clr_pct > 0) && (int'($urandom_range(99)) < clr_pct));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_locked", int'(bus.o_locked),    0);
    chk("rst_period", int'(bus.o_period),    0);
    chk("rst_err",    int'(bus.o_err_count), 0);
    chk("rst_error",  int'(bus.o_error),     0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    int gaps [8] = '{5, 5, 5, 5, 3, 6, 11, 2};
    int g;
    bus.i_enable = 0; bus.i_strobe = 0; bus.i_clear_errors = 0;
    model_reset();
    #12;
    chk("init_locked", int'(bus.o_locked),    0);
    chk("init_period", int'(bus.o_period),    0);
    chk("init_err",    int'(bus.o_err_count), 0);
    chk("init_error",  int'(bus.o_error),     0);
    @(negedge clk);
    rst = 1'b0;

    // Nominal period 5, then short interval, then resume.
    repeat (7) period(5, 1, 0, 0);
    period(3, 1, 0, 0);
    repeat (3) period(5, 1, 0, 0);

    // Strobe stops: two missing-strobe errors and loss of lock.
    step(1'b1, 1'b1, 1'b0);
    repeat (24) step(1'b1, 1'b0, 1'b0);

    // Enable low every other cycle, period counted in enabled cycles.
    repeat (7) period(5, 1, 100, 0);

    // Strobe held high three cycles per period.
    repeat (7) period(5, 3, 0, 0);

    // Build err_count to 7 while locked, then reset asynchronously.
    do_reset();
    repeat (6) period(5, 1, 0, 0);
    repeat (7) begin
      period(3, 1, 0, 0);
      period(5, 1, 0, 0);
    end
    do_reset();

    // Clear coincident with an error.
    repeat (6) period(5, 1, 0, 0);
    period(3, 1, 0, 0);
    period(5, 1, 0, 0);
    period(3, 1, 0, 0);
    step(1'b1, 1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    repeat (3) period(5, 1, 0, 0);

    // Randomized mix of spacings, holds, disabled cycles and clears.
    repeat (300) begin
      g = gaps[$urandom_range(7)];
      period(g, int'($urandom_range(1, g - 1)), 25, 3);
    end

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/strobe_monitor.md
Name: strobe_monitor

Overview:
- Receive-side checker for the periodic valid strobe produced by the enable-gated strobe counter.
- Samples the strobe on enabled cycles, measures the spacing between rising edges, and locks once the spacing repeatedly matches the expected period.
- While locked, flags wrong-period and missing strobes and counts errors.
- Sits at the downstream end of the strobe path, next to the decimator/sampler, for bring-up and ILA visibility.

Parameters:
- CNT_WIDTH, 8: width of the interval counter and of o_period. Must satisfy 2*EXP_PERIOD <= 2^CNT_WIDTH-1.
- EXP_PERIOD, 5: expected rising-edge spacing, in enabled cycles (>= 2).
- LOCK_COUNT, 4: consecutive matching intervals needed to lock (>= 1).
- UNLOCK_COUNT, 2: consecutive bad events needed to drop lock (>= 1).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  sampling qualifier; state advances only when high.
- i_strobe  in  1  strobe under test; may be held high for several cycles.
- i_clear_errors  in  1  synchronous clear of o_err_count; acts regardless of i_enable.
- o_locked  out  1  high while in LOCKED.
- o_period  out  CNT_WIDTH  last measured interval, saturating.
- o_err_count  out  16  saturating error counter.
- o_error  out  1  one-cycle pulse per error event.

Behaviour:
- Reset (async, any time, including mid-interval): state=IDLE, strb_d=0, interval=0, good=0, bad=0. All outputs 0. Operation resumes on the first clock edge after deassertion.
- i_enable=0: all state holds; o_error=0.
- Edge detect, enabled cycles only: edge = i_strobe & ~strb_d; strb_d <= i_strobe.
- Interval counter, enabled cycles only: on an edge, interval <= 0; otherwise interval <= interval+1, saturating at all-ones. Measured period M = interval+1, evaluated on the edge cycle.
- On every edge after the first: o_period <= M, saturating to all-ones.
- IDLE: first edge -> TRACK. o_period is not updated on this edge.
- TRACK, on an edge:
  - M==EXP_PERIOD: good++. If good reaches LOCK_COUNT -> LOCKED, good=0, bad=0.
  - M!=EXP_PERIOD: good=0, stay in TRACK.
  - No errors are counted or pulsed in TRACK. No timeout.
- LOCKED, on an edge:
  - M==EXP_PERIOD: bad=0.
  - M!=EXP_PERIOD: bad event.
- LOCKED, missing strobe: an enabled cycle without an edge that would make interval reach 2*EXP_PERIOD. interval <= 0 instead, and this is a bad event.
- Bad event: o_error pulses 1 on the next cycle; o_err_count++ (saturating at 0xFFFF); bad++. If bad reaches UNLOCK_COUNT -> TRACK, good=0, bad=0.
- o_locked is registered: it rises/falls on the clock edge that performs the state change.
- i_clear_errors:
  - Sets o_err_count to 0 on the next edge.
  - If a bad event occurs in the same cycle, o_err_count becomes 1 and o_error still pulses.
- Counters never wrap.

Test Plan:
- 1. Rising edges every 5 enabled cycles, i_enable=1 -> o_period=5 after the 2nd edge; o_locked=1 one cycle after the 5th edge (1 + LOCK_COUNT); o_err_count=0.
- 2. Locked, then one edge arrives after 3 cycles, then resumes period 5 -> single o_error pulse, o_err_count=1, o_period=3 then 5, o_locked stays 1.
- 3. Locked, then strobe stops -> o_error pulses 10 and 20 cycles after the last edge; o_err_count=2; o_locked falls with the second pulse.
- 4. Period-5 strobe with i_enable low 1 of every 2 cycles, period counted in enabled cycles -> locks normally; no errors; state frozen on disabled cycles.
- 5. Strobe held high 3 cycles per period -> only rising edges counted; o_period=5; lock reached.
- 6. i_reset pulsed asynchronously while locked with o_err_count=7 -> all outputs 0 immediately, IDLE. Clear coincident with an error -> o_err_count=1.
